// File: rtl/regfile_param_pkg.sv
// ============================================================================
// regfile_param_pkg : clear-FSM state encoding and default geometry
// Revision 1.0
// ============================================================================
`default_nettype none

package regfile_param_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_DEFAULT_WIDTH = 32;
  localparam int RF_DEFAULT_DEPTH = 32;

endpackage

`default_nettype wire

// File: rtl/rf_clear_ctrl.sv
// ============================================================================
// rf_clear_ctrl : sequential clear engine, zeroes one entry per cycle after reset
// Revision 1.0
// ============================================================================
`default_nettype none

module rf_clear_ctrl
  import regfile_param_pkg::*;
#(
  parameter int DEPTH = RF_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          ready_q, ready_d;

  // The pointer parks on the last entry so it never runs past DEPTH-1.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    if (state_q == RF_CLEAR) begin
      if (clr_ptr_q == LAST_ADDR) begin
        state_d = RF_RUN;
        ready_d = 1'b1;
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  assign clr_we   = rst_n && (state_q == RF_CLEAR);
  assign clr_addr = clr_ptr_q;
  assign ready    = ready_q;

endmodule

`default_nettype wire

// File: rtl/regfile_param.sv
// ============================================================================
// regfile_param : parametrised 2R/1W register file with zero reg, bypass, clear
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_param
  import regfile_param_pkg::*;
#(
  parameter  int WIDTH    = RF_DEFAULT_WIDTH,
  parameter  int DEPTH    = RF_DEFAULT_DEPTH,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             ready
);

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             fn_we;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_q [DEPTH];

  rf_clear_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // Reset gates the functional port so a write in a reset cycle is lost
  // even while ready is still high.
  always_comb begin
    fn_we = rst_n && ready && we3 && (32'(wa3) < DEPTH);
    if (ZERO_REG != 0 && wa3 == '0) begin
      fn_we = 1'b0;
    end
    mem_we = clr_we || fn_we;
    mem_wa = clr_we ? clr_addr : wa3;
    mem_wd = clr_we ? '0 : wd3;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  function automatic logic [WIDTH-1:0] read_mux(input logic [AW-1:0]    ra,
                                                input logic [WIDTH-1:0] stored);
    logic [WIDTH-1:0] val;
    val = stored;
    if (!ready || 32'(ra) >= DEPTH) begin
      val = '0;
    end else if (ZERO_REG != 0 && ra == '0) begin
      val = '0;
    end else if (BYPASS != 0 && we3 && wa3 == ra) begin
      val = wd3;
    end
    return val;
  endfunction

  assign rd1 = read_mux(ra1, mem_q[ra1]);
  assign rd2 = read_mux(ra2, mem_q[ra2]);

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
// Bench: two instances (default 32x32 with zero reg + bypass; 16x12 without)
// checked every cycle against an array model of the register file.
`default_nettype none

module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        we    [2];
  logic [4:0]  wa    [2];
  logic [4:0]  ra1   [2];
  logic [4:0]  ra2   [2];
  logic [31:0] wd    [2];

  logic [31:0] rd1_a, rd2_a;
  logic [15:0] rd1_b, rd2_b;
  logic        ready_a, ready_b;

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n[0]),
    .we3   (we[0]),
    .wa3   (wa[0]),
    .wd3   (wd[0]),
    .ra1   (ra1[0]),
    .ra2   (ra2[0]),
    .rd1   (rd1_a),
    .rd2   (rd2_a),
    .ready (ready_a)
  );

  regfile_param #(.WIDTH(16), .DEPTH(12), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk   (clk),
    .rst_n (rst_n[1]),
    .we3   (we[1]),
    .wa3   (wa[1][3:0]),
    .wd3   (wd[1][15:0]),
    .ra1   (ra1[1][3:0]),
    .ra2   (ra2[1][3:0]),
    .rd1   (rd1_b),
    .rd2   (rd2_b),
    .ready (ready_b)
  );

  // Reference model parameters and state
  int          dep   [2] = '{32, 12};
  bit          zr    [2] = '{1'b1, 1'b0};
  bit          bp    [2] = '{1'b1, 1'b0};
  logic [31:0] wmask [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] mm    [2][32];
  bit          mrdy  [2];
  int          mcnt  [2];

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int k, input logic [4:0] ra);
    if (!mrdy[k]) return 32'h0;
    if (zr[k] && ra == 5'd0) return 32'h0;
    if (int'(ra) >= dep[k]) return 32'h0;
    if (bp[k] && we[k] && wa[k] == ra) return wd[k] & wmask[k];
    return mm[k][ra];
  endfunction

  task automatic model_edge(input int k);
    if (!rst_n[k]) begin
      mrdy[k] = 1'b0;
      mcnt[k] = 0;
    end else begin
      if (mrdy[k] && we[k] && int'(wa[k]) < dep[k] && !(zr[k] && wa[k] == 5'd0))
        mm[k][wa[k]] = wd[k] & wmask[k];
      if (!mrdy[k]) begin
        mcnt[k]++;
        if (mcnt[k] == dep[k]) begin
          mrdy[k] = 1'b1;
          for (int i = 0; i < 32; i++) mm[k][i] = 32'h0;
        end
      end
    end
  endtask

  function automatic logic [31:0] obs_rd1(input int k);
    return (k == 0) ? rd1_a : {16'h0, rd1_b};
  endfunction

  function automatic logic [31:0] obs_rd2(input int k);
    return (k == 0) ? rd2_a : {16'h0, rd2_b};
  endfunction

  function automatic logic obs_rdy(input int k);
    return (k == 0) ? ready_a : ready_b;
  endfunction

  // Check outputs against the model, then take one clock edge.
  task automatic tick();
    string nm;
    #1;
    for (int k = 0; k < 2; k++) begin
      nm = (k == 0) ? "a" : "b";
      check_eq({nm, "_ready"}, 32'(obs_rdy(k)), 32'(mrdy[k]));
      check_eq({nm, "_rd1"}, obs_rd1(k), exp_rd(k, ra1[k]));
      check_eq({nm, "_rd2"}, obs_rd2(k), exp_rd(k, ra2[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
  endtask

  task automatic rand_in(input int k);
    int amax;
    amax   = (k == 0) ? 31 : 15;
    we[k]  = 1'($urandom_range(0, 1));
    wa[k]  = 5'($urandom_range(0, amax));
    wd[k]  = $urandom & wmask[k];
    ra1[k] = ($urandom_range(0, 3) == 0) ? wa[k] : 5'($urandom_range(0, amax));
    ra2[k] = ($urandom_range(0, 3) == 0) ? ra1[k] : 5'($urandom_range(0, amax));
  endtask

  task automatic idle(input int k);
    we[k] = 1'b0; wa[k] = 5'd0; wd[k] = 32'h0; ra1[k] = 5'd0; ra2[k] = 5'd0;
  endtask

  int e, eb;
  logic [31:0] v;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      idle(k);
      mrdy[k] = 1'b0;
      mcnt[k] = 0;
      for (int i = 0; i < 32; i++) mm[k][i] = 32'h0;
    end
    @(posedge clk);
    #1;

    // Reset held, then release and count edges to ready
    repeat (3) tick();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    e = 0; eb = -1;
    while (!ready_a && e < 100) begin
      rand_in(0); rand_in(1);
      tick();
      e++;
      if (ready_b && eb < 0) eb = e;
    end
    check_eq("rdy_edges_a", 32'(e), 32'd32);
    check_eq("rdy_edges_b", 32'(eb), 32'd12);
    idle(0); idle(1);

    // Basic write/read
    we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF;
    tick();
    idle(0); ra1[0] = 5'd5; ra2[0] = 5'd6;
    #1;
    check_eq("wr_rd_5", rd1_a, 32'hDEAD_BEEF);
    check_eq("rd_6_zero", rd2_a, 32'h0);
    tick();

    // Bypass (A) vs no bypass (B)
    we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h1111;
    tick();
    we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h1234_5678; ra1[0] = 5'd9; ra2[0] = 5'd9;
    we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h5678;      ra1[1] = 5'd9; ra2[1] = 5'd9;
    #1;
    check_eq("byp_rd1", rd1_a, 32'h1234_5678);
    check_eq("byp_rd2", rd2_a, 32'h1234_5678);
    check_eq("nobyp_old", {16'h0, rd1_b}, 32'h1111);
    tick();
    we[0] = 1'b0; we[1] = 1'b0;
    #1;
    check_eq("nobyp_new", {16'h0, rd2_b}, 32'h5678);
    tick();

    // Zero register
    we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF; ra1[0] = 5'd0;
    we[1] = 1'b1; wa[1] = 5'd0; wd[1] = 32'hFFFF;      ra1[1] = 5'd0;
    #1;
    check_eq("zr_same", rd1_a, 32'h0);
    tick();
    we[0] = 1'b0; we[1] = 1'b0;
    #1;
    check_eq("zr_next", rd1_a, 32'h0);
    check_eq("nozr_next", {16'h0, rd1_b}, 32'hFFFF);
    tick();

    // Full address sweep on the small instance, then out-of-range
    for (int a = 0; a < 12; a++) begin
      v = $urandom & 32'hFFFF;
      we[1] = 1'b1; wa[1] = 5'(a); wd[1] = v;
      tick();
      we[1] = 1'b0; ra1[1] = 5'(a);
      #1;
      check_eq("sweep_rd", {16'h0, rd1_b}, v);
      tick();
    end
    we[1] = 1'b1; wa[1] = 5'd13; wd[1] = 32'hBEEF;
    tick();
    we[1] = 1'b0; ra1[1] = 5'd13;
    #1;
    check_eq("oor_rd13", {16'h0, rd1_b}, 32'h0);
    tick();

    // Random traffic
    repeat (400) begin
      rand_in(0); rand_in(1);
      tick();
    end
    idle(0); idle(1);

    // Reset mid-clear
    we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hA5A5_A5A5;
    tick();
    idle(0); ra1[0] = 5'd3;
    #1;
    check_eq("pre_rst_3", rd1_a, 32'hA5A5_A5A5);
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    tick();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (10) begin
      rand_in(0); rand_in(1);
      tick();
    end
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    tick();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    idle(1);
    e = 0;
    while (!ready_a && e < 100) begin
      we[0] = 1'b1; wa[0] = 5'd7; wd[0] = $urandom;
      ra1[0] = 5'($urandom_range(0, 31)); ra2[0] = 5'd7;
      tick();
      e++;
    end
    check_eq("restart_edges", 32'(e), 32'd32);
    idle(0); ra1[0] = 5'd3; ra2[0] = 5'd7;
    #1;
    check_eq("post_rst_3", rd1_a, 32'h0);
    check_eq("clr_we_7", rd2_a, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
